// File: rtl/store_sequencer.sv
// Store sequencer: turns word (SW) and byte (SB) store requests into memory
// write transactions, using read-modify-write for byte stores.
module store_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_req,
  input  logic              st_byte,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_busy,
  output logic              st_done,
  output logic              st_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              st_busy_q, st_busy_d;
  logic              st_done_q, st_done_d;
  logic              st_err_q, st_err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       merged;

  // Replace only the addressed little-endian byte lane of the read word.
  always_comb begin
    merged = mem_rdata;
    case (lane_q)
      2'd0: merged[7:0]   = byte_data_q;
      2'd1: merged[15:8]  = byte_data_q;
      2'd2: merged[23:16] = byte_data_q;
      default: merged[31:24] = byte_data_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    byte_data_d = byte_data_q;
    st_busy_d   = st_busy_q;
    st_done_d   = 1'b0;
    st_err_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (st_req) begin
          lane_d      = st_addr[1:0];
          byte_data_d = st_data[7:0];
          st_busy_d   = 1'b1;
          mem_addr_d  = {st_addr[ADDR_W-1:2], 2'b00};
          if (st_byte) begin
            state_d  = RD;
            mem_rd_d = 1'b1;
          end else if (st_addr[1:0] != 2'b00) begin
            // Misaligned word store completes with an error and never touches memory.
            state_d   = DONE;
            st_done_d = 1'b1;
            st_err_d  = 1'b1;
          end else begin
            state_d     = WR;
            mem_wr_d    = 1'b1;
            mem_wdata_d = st_data;
          end
        end
      end
      RD: begin
        if (mem_ready) begin
          state_d     = WR;
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b1;
          mem_wdata_d = merged;
        end
      end
      WR: begin
        if (mem_ready) begin
          state_d   = DONE;
          mem_wr_d  = 1'b0;
          st_done_d = 1'b1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        st_busy_d = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        st_busy_d = 1'b0;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lane_q      <= 2'd0;
      byte_data_q <= 8'd0;
      st_busy_q   <= 1'b0;
      st_done_q   <= 1'b0;
      st_err_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      byte_data_q <= byte_data_d;
      st_busy_q   <= st_busy_d;
      st_done_q   <= st_done_d;
      st_err_q    <= st_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign st_busy   = st_busy_q;
  assign st_done   = st_done_q;
  assign st_err    = st_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Directed testbench for store_sequencer: word, byte, wait-state, misaligned,
// reset-abort and back-to-back request scenarios with hand-computed results.
module tb_store_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_req;
  logic        st_byte;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_busy;
  logic        st_done;
  logic        st_err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_tests = 0;
  int n_failed = 0;

  store_sequencer #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_req    (st_req),
    .st_byte   (st_byte),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_busy   (st_busy),
    .st_done   (st_done),
    .st_err    (st_err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge so outputs have settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic is_byte,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] rdata, input logic ready);
    st_req    = req;
    st_byte   = is_byte;
    st_addr   = addr;
    st_data   = data;
    mem_rdata = rdata;
    mem_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkCtl(input string tag, input logic busy, input logic done,
                          input logic err, input logic rd, input logic wr);
    checkOutput({tag, ".busy"}, {31'd0, st_busy}, {31'd0, busy});
    checkOutput({tag, ".done"}, {31'd0, st_done}, {31'd0, done});
    checkOutput({tag, ".err"},  {31'd0, st_err},  {31'd0, err});
    checkOutput({tag, ".rd"},   {31'd0, mem_rd},  {31'd0, rd});
    checkOutput({tag, ".wr"},   {31'd0, mem_wr},  {31'd0, wr});
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    step();
    checkCtl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.addr", mem_addr, 32'h0);
    checkOutput("reset.wdata", mem_wdata, 32'h0);

    // Aligned word store, zero wait; accepted in the first cycle after reset.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1);
    step();
    st_req = 1'b0;
    checkCtl("sw.c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sw.c1.addr", mem_addr, 32'h100);
    checkOutput("sw.c1.wdata", mem_wdata, 32'hDEADBEEF);
    step();
    checkCtl("sw.c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkCtl("sw.c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Byte store lane 2, zero wait; upper st_data bits must be ignored.
    applyStimulus(1'b1, 1'b1, 32'h102, 32'hABCDEF5A, 32'h11223344, 1'b1);
    step();
    st_req = 1'b0;
    checkCtl("sb.c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sb.c1.addr", mem_addr, 32'h100);
    step();
    checkCtl("sb.c2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sb.c2.addr", mem_addr, 32'h100);
    checkOutput("sb.c2.wdata", mem_wdata, 32'h115A3344);
    step();
    checkCtl("sb.c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkCtl("sb.c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Byte store lane 3 with two RD wait cycles and one WR wait cycle.
    applyStimulus(1'b1, 1'b1, 32'h203, 32'h000000FF, 32'hFFFFFFFF, 1'b0);
    step();
    st_req = 1'b0;
    checkCtl("sbw.c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sbw.c1.addr", mem_addr, 32'h200);
    step();
    checkCtl("sbw.c2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    checkCtl("sbw.c3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    mem_ready = 1'b1;
    mem_rdata = 32'h00000000;
    step();
    mem_ready = 1'b0;
    mem_rdata = 32'hFFFFFFFF;
    checkCtl("sbw.c4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sbw.c4.wdata", mem_wdata, 32'hFF000000);
    step();
    checkCtl("sbw.c5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sbw.c5.wdata", mem_wdata, 32'hFF000000);
    checkOutput("sbw.c5.addr", mem_addr, 32'h200);
    mem_ready = 1'b1;
    step();
    checkCtl("sbw.c6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkCtl("sbw.c7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Misaligned word store: error completion, no memory access.
    applyStimulus(1'b1, 1'b0, 32'h101, 32'h12345678, 32'h0, 1'b1);
    step();
    st_req = 1'b0;
    checkCtl("mis.c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checkCtl("mis.c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the second WR cycle aborts the store.
    applyStimulus(1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0, 1'b0);
    step();
    st_req = 1'b0;
    checkCtl("rst.c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checkCtl("rst.c2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    checkCtl("rst.c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst.c3.addr", mem_addr, 32'h0);
    checkOutput("rst.c3.wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1);
    step();
    st_req = 1'b0;
    checkCtl("rsw.c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rsw.c1.addr", mem_addr, 32'h100);
    checkOutput("rsw.c1.wdata", mem_wdata, 32'hDEADBEEF);
    step();
    checkCtl("rsw.c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkCtl("rsw.c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // st_req held high: one word store every three cycles, data changes while busy ignored.
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h00000001, 32'h0, 1'b1);
    step();
    st_data = 32'h00000002;
    checkCtl("b2b.c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("b2b.c1.wdata", mem_wdata, 32'h00000001);
    step();
    checkCtl("b2b.c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkCtl("b2b.c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkCtl("b2b.c4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("b2b.c4.wdata", mem_wdata, 32'h00000002);
    step();
    checkCtl("b2b.c5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    st_req = 1'b0;
    step();
    checkCtl("b2b.c6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
